// File: rtl/step_decoder_pkg.sv
// step_decoder_pkg: shared constants and helpers for the step/dir receive path.
//   POS_W              width of the signed position accumulator
//   DIR_POS            dir level that means "positive step"
//   INTERVAL_W_DEFAULT default width of the step-interval counter
//   pulse_state_e      states of the step pulse-width FSM
//   step_delta()       +1 / -1 increment for a step in the given direction
package step_decoder_pkg;

  localparam int   POS_W              = 64;
  localparam logic DIR_POS            = 1'b1;
  localparam int   INTERVAL_W_DEFAULT = 32;

  typedef enum logic {
    ST_LOW  = 1'b0,
    ST_HIGH = 1'b1
  } pulse_state_e;

  // Two's complement +1 or -1; the caller's add wraps silently at +/-2^63.
  function automatic logic [POS_W-1:0] step_delta(input logic dir);
    return (dir == DIR_POS) ? POS_W'(1) : {POS_W{1'b1}};
  endfunction

endpackage

// File: rtl/step_decoder_sync2.sv
// step_decoder_sync2: two-flop synchronizer for one asynchronous input bit.
//   clk    system clock
//   reset  asynchronous active-high reset, clears both stages
//   d      asynchronous input
//   q      synchronized output (two clk edges after d is sampled)
module step_decoder_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/step_decoder.sv
// step_decoder: receive side of a step/dir interface.
//   Synchronizes step_in/dir_in, accumulates a signed 64-bit position,
//   measures the step-to-step interval and flags pulse-width and dir-setup
//   violations.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   step_in, dir_in      asynchronous step pulse and direction (1 = positive)
//   set_pos, pos_val     load pos_val into position (wins over a coincident step)
//   clear_err            clear sticky error flags (a new error in that cycle wins)
//   position             signed accumulated position
//   step_seen            one-cycle pulse per accepted step rising edge
//   interval             clk cycles between the last two step rising edges
//   interval_valid       interval holds a real measurement
//   err_short            sticky: a step high time was shorter than MIN_PULSE
//   err_setup            sticky: step rose within DIR_SETUP cycles of a dir change
module step_decoder
  import step_decoder_pkg::*;
#(
  parameter int INTERVAL_W = INTERVAL_W_DEFAULT,
  parameter int MIN_PULSE  = 4,
  parameter int DIR_SETUP  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    step_in,
  input  logic                    dir_in,
  input  logic                    set_pos,
  input  logic signed [POS_W-1:0] pos_val,
  input  logic                    clear_err,
  output logic signed [POS_W-1:0] position,
  output logic                    step_seen,
  output logic [INTERVAL_W-1:0]   interval,
  output logic                    interval_valid,
  output logic                    err_short,
  output logic                    err_setup
);

  localparam int HC_W = (MIN_PULSE < 1) ? 1 : $clog2(MIN_PULSE + 1);
  localparam int DC_W = (DIR_SETUP < 1) ? 1 : $clog2(DIR_SETUP + 1);
  localparam logic [HC_W-1:0] HC_MAX = HC_W'(MIN_PULSE);
  localparam logic [DC_W-1:0] DC_MAX = DC_W'(DIR_SETUP);

  logic step_s2;
  logic dir_s2;

  step_decoder_sync2 u_sync_step (.clk(clk), .reset(reset), .d(step_in), .q(step_s2));
  step_decoder_sync2 u_sync_dir  (.clk(clk), .reset(reset), .d(dir_in),  .q(dir_s2));

  logic                  step_prev_q, step_prev_d;
  logic                  dir_prev_q,  dir_prev_d;
  logic [POS_W-1:0]      position_q,  position_d;
  logic                  step_seen_q, step_seen_d;
  logic [INTERVAL_W-1:0] ctr_q,       ctr_d;
  logic [INTERVAL_W-1:0] interval_q,  interval_d;
  logic                  valid_q,     valid_d;
  logic                  armed_q,     armed_d;
  logic                  err_short_q, err_short_d;
  logic                  err_setup_q, err_setup_d;
  logic [HC_W-1:0]       high_cnt_q,  high_cnt_d;
  logic [DC_W-1:0]       dir_cnt_q,   dir_cnt_d;
  pulse_state_e          state_q,     state_d;

  logic rise;
  logic fall;
  logic dir_chg;
  logic new_short;
  logic new_setup;

  assign rise    = step_s2 & ~step_prev_q;
  assign fall    = ~step_s2 & step_prev_q;
  assign dir_chg = dir_s2 ^ dir_prev_q;

  always_comb begin
    step_prev_d = step_s2;
    dir_prev_d  = dir_s2;
    position_d  = position_q;
    step_seen_d = rise;
    interval_d  = interval_q;
    valid_d     = valid_q;
    armed_d     = armed_q;
    state_d     = state_q;
    high_cnt_d  = high_cnt_q;
    new_short   = 1'b0;

    // Free-running interval counter, parked at all-ones once saturated.
    ctr_d = (&ctr_q) ? ctr_q : ctr_q + INTERVAL_W'(1);

    // Cycles since the last synchronized dir change. The rise check uses the
    // updated value so a dir change in the rise cycle itself counts as 0.
    if (dir_chg) begin
      dir_cnt_d = '0;
    end else if (dir_cnt_q >= DC_MAX) begin
      dir_cnt_d = dir_cnt_q;
    end else begin
      dir_cnt_d = dir_cnt_q + DC_W'(1);
    end
    new_setup = rise && (dir_cnt_d < DC_MAX);

    // Pulse-width FSM: high_cnt counts synchronized high cycles, including
    // the rise cycle, up to MIN_PULSE.
    case (state_q)
      ST_LOW: begin
        if (rise) begin
          state_d    = ST_HIGH;
          high_cnt_d = HC_W'(1);
        end
      end
      ST_HIGH: begin
        if (fall) begin
          state_d   = ST_LOW;
          new_short = (high_cnt_q < HC_MAX);
        end else if (high_cnt_q < HC_MAX) begin
          high_cnt_d = high_cnt_q + HC_W'(1);
        end
      end
      default: state_d = ST_LOW;
    endcase

    if (rise) begin
      interval_d = (&ctr_q) ? ctr_q : ctr_q + INTERVAL_W'(1);
      ctr_d      = '0;
      // The first rise after reset/set_pos only arms; it has no predecessor.
      if (armed_q) begin
        valid_d = 1'b1;
      end
      armed_d    = 1'b1;
      position_d = position_q + step_delta(dir_s2);
    end

    // A position load overrides any coincident step and restarts timing.
    if (set_pos) begin
      position_d = pos_val;
      armed_d    = 1'b0;
      valid_d    = 1'b0;
      ctr_d      = '0;
    end

    err_short_d = (clear_err ? 1'b0 : err_short_q) | new_short;
    err_setup_d = (clear_err ? 1'b0 : err_setup_q) | new_setup;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_prev_q <= 1'b0;
      dir_prev_q  <= 1'b0;
      position_q  <= '0;
      step_seen_q <= 1'b0;
      ctr_q       <= '0;
      interval_q  <= '0;
      valid_q     <= 1'b0;
      armed_q     <= 1'b0;
      err_short_q <= 1'b0;
      err_setup_q <= 1'b0;
      high_cnt_q  <= '0;
      dir_cnt_q   <= DC_MAX;
      state_q     <= ST_LOW;
    end else begin
      step_prev_q <= step_prev_d;
      dir_prev_q  <= dir_prev_d;
      position_q  <= position_d;
      step_seen_q <= step_seen_d;
      ctr_q       <= ctr_d;
      interval_q  <= interval_d;
      valid_q     <= valid_d;
      armed_q     <= armed_d;
      err_short_q <= err_short_d;
      err_setup_q <= err_setup_d;
      high_cnt_q  <= high_cnt_d;
      dir_cnt_q   <= dir_cnt_d;
      state_q     <= state_d;
    end
  end

  assign position       = position_q;
  assign step_seen      = step_seen_q;
  assign interval       = interval_q;
  assign interval_valid = valid_q;
  assign err_short      = err_short_q;
  assign err_setup      = err_setup_q;

endmodule

// File: tb/tb_step_decoder.sv
// tb_step_decoder: directed plus randomized stimulus for step_decoder,
// checked every cycle against a behavioural model of the step/dir rules.
module tb_step_decoder;

  localparam int IW = 8;
  localparam int MP = 4;
  localparam int DS = 2;
  localparam int IMAX = (1 << IW) - 1;

  logic               clk = 1'b0;
  logic               reset;
  logic               step_in;
  logic               dir_in;
  logic               set_pos;
  logic signed [63:0] pos_val;
  logic               clear_err;
  logic signed [63:0] position;
  logic               step_seen;
  logic [IW-1:0]      interval;
  logic               interval_valid;
  logic               err_short;
  logic               err_setup;

  step_decoder #(.INTERVAL_W(IW), .MIN_PULSE(MP), .DIR_SETUP(DS)) dut (
    .clk(clk), .reset(reset), .step_in(step_in), .dir_in(dir_in),
    .set_pos(set_pos), .pos_val(pos_val), .clear_err(clear_err),
    .position(position), .step_seen(step_seen), .interval(interval),
    .interval_valid(interval_valid), .err_short(err_short), .err_setup(err_setup)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int seen_cnt = 0;

  // Reference model state
  logic [63:0] m_pos;
  bit          m_seen, m_valid, m_armed, m_es, m_ed;
  int          m_int;
  int          en, last_rise, last_chg, run;
  bit          sq[$];
  bit          dq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = '0; m_seen = 0; m_valid = 0; m_armed = 0; m_es = 0; m_ed = 0;
    m_int = 0; en = 0; last_rise = 0; last_chg = -1000; run = 0;
    sq = '{0, 0, 0};
    dq = '{0, 0, 0};
  endtask

  // Inputs sampled at edge n are seen by the decoder logic two edges later;
  // a step edge at input sample n-2 vs n-3 is registered at edge n.
  task automatic model_edge();
    bit s2, s3, d2, d3, rise, fall, nshort, nsetup;
    en++;
    sq.push_back(step_in);
    dq.push_back(dir_in);
    if (sq.size() > 8) void'(sq.pop_front());
    if (dq.size() > 8) void'(dq.pop_front());
    s2 = sq[sq.size()-3]; s3 = sq[sq.size()-4];
    d2 = dq[dq.size()-3]; d3 = dq[dq.size()-4];
    rise = s2 && !s3;
    fall = !s2 && s3;
    if (d2 != d3) last_chg = en;
    nshort = fall && (run < MP);
    nsetup = rise && ((en - last_chg) < DS);
    run = s2 ? run + 1 : 0;
    m_seen = rise;
    if (rise) begin
      if (m_armed) begin
        m_int   = ((en - last_rise) > IMAX) ? IMAX : (en - last_rise);
        m_valid = 1;
      end
      m_armed   = 1;
      last_rise = en;
      m_pos     = d2 ? m_pos + 64'd1 : m_pos - 64'd1;
    end
    if (set_pos) begin
      m_pos   = pos_val;
      m_armed = 0;
      m_valid = 0;
    end
    m_es = (clear_err ? 1'b0 : m_es) | nshort;
    m_ed = (clear_err ? 1'b0 : m_ed) | nsetup;
  endtask

  task automatic check_outputs();
    chk("position", position, m_pos);
    chk("step_seen", {63'd0, step_seen}, {63'd0, m_seen});
    chk("interval_valid", {63'd0, interval_valid}, {63'd0, m_valid});
    if (m_valid) chk("interval", {56'd0, interval}, 64'(m_int));
    chk("err_short", {63'd0, err_short}, {63'd0, m_es});
    chk("err_setup", {63'd0, err_setup}, {63'd0, m_ed});
    if (step_seen === 1'b1) seen_cnt++;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic pulse(input int high, input int low);
    step_in = 1'b1;
    repeat (high) cyc();
    step_in = 1'b0;
    repeat (low) cyc();
  endtask

  task automatic pulse_clear_err();
    clear_err = 1'b1;
    cyc();
    clear_err = 1'b0;
  endtask

  initial begin
    reset = 1'b1; step_in = 0; dir_in = 0; set_pos = 0; clear_err = 0; pos_val = '0;
    model_reset();
    #2;
    chk("reset_position", position, 64'd0);
    chk("reset_flags", {58'd0, step_seen, interval_valid, err_short, err_setup, 2'b00}, 64'd0);
    chk("reset_interval", {56'd0, interval}, 64'd0);
    #6 reset = 1'b0;

    // Five positive steps, 8 high, 20 cycles apart
    dir_in = 1'b1;
    idle(5);
    seen_cnt = 0;
    repeat (5) pulse(8, 12);
    chk("p1_position", position, 64'd5);
    chk("p1_seen_count", 64'(seen_cnt), 64'd5);
    chk("p1_interval", {56'd0, interval}, 64'd20);
    chk("p1_valid", {63'd0, interval_valid}, 64'd1);
    chk("p1_errors", {62'd0, err_short, err_setup}, 64'd0);

    // Load -3, then two negative steps
    set_pos = 1'b1; pos_val = -64'sd3;
    cyc();
    set_pos = 1'b0;
    dir_in = 1'b0;
    idle(5);
    pulse(8, 12);
    chk("p2_valid_first", {63'd0, interval_valid}, 64'd0);
    pulse(8, 12);
    chk("p2_valid_second", {63'd0, interval_valid}, 64'd1);
    chk("p2_position", position, 64'hFFFF_FFFF_FFFF_FFFB);

    // Short pulse
    pulse(2, 10);
    chk("p3_err_short", {63'd0, err_short}, 64'd1);
    chk("p3_position", position, 64'hFFFF_FFFF_FFFF_FFFA);
    pulse_clear_err();
    chk("p3_err_short_cleared", {63'd0, err_short}, 64'd0);

    // Dir setup violation, then a clean step after a 5-cycle gap
    dir_in = 1'b1;
    cyc();
    pulse(8, 12);
    chk("p4_err_setup", {63'd0, err_setup}, 64'd1);
    pulse_clear_err();
    dir_in = 1'b0;
    idle(5);
    pulse(8, 12);
    chk("p4_no_err_setup", {63'd0, err_setup}, 64'd0);

    // Interval saturation
    dir_in = 1'b1;
    idle(3);
    pulse(8, 292);
    pulse(8, 292);
    chk("p5_interval_sat", {56'd0, interval}, 64'd255);
    chk("p5_valid", {63'd0, interval_valid}, 64'd1);

    // set_pos coincident with a registered rise
    step_in = 1'b1;
    cyc();
    cyc();
    set_pos = 1'b1; pos_val = 64'sd1000;
    cyc();
    set_pos = 1'b0;
    chk("p6_position", position, 64'd1000);
    chk("p6_step_seen", {63'd0, step_seen}, 64'd1);
    repeat (6) cyc();
    step_in = 1'b0;
    idle(10);

    // Wrap at +2^63
    set_pos = 1'b1; pos_val = 64'sh7FFF_FFFF_FFFF_FFFF;
    cyc();
    set_pos = 1'b0;
    pulse(8, 12);
    chk("p7_wrap", position, 64'h8000_0000_0000_0000);

    // Randomized step trains with dir changes, clears and loads
    for (int i = 0; i < 60; i++) begin
      int high;
      int low;
      high = $urandom_range(1, 10);
      low  = $urandom_range(1, 30);
      if ($urandom_range(0, 7) == 0) dir_in = ~dir_in;
      step_in = 1'b1;
      repeat (high) cyc();
      step_in = 1'b0;
      for (int j = 0; j < low; j++) begin
        if ($urandom_range(0, 15) == 0) dir_in = ~dir_in;
        clear_err = ($urandom_range(0, 19) == 0);
        set_pos   = ($urandom_range(0, 39) == 0);
        pos_val   = {$urandom, $urandom};
        cyc();
      end
      clear_err = 1'b0;
      set_pos   = 1'b0;
    end
    idle(5);

    // Reset in the middle of a pulse
    dir_in = 1'b0;
    idle(4);
    step_in = 1'b1;
    repeat (3) cyc();
    reset = 1'b1;
    #2;
    chk("p9_rst_position", position, 64'd0);
    chk("p9_rst_flags", {60'd0, step_seen, interval_valid, err_short, err_setup}, 64'd0);
    chk("p9_rst_interval", {56'd0, interval}, 64'd0);
    model_reset();
    #2 reset = 1'b0;
    repeat (10) cyc();
    step_in = 1'b0;
    idle(10);
    chk("p9_position_after", position, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("p9_no_errors", {62'd0, err_short, err_setup}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
